// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct
// constants, ALU operation codes and mux select values.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXE, S_R_WB, S_I_EXE, S_I_WB, S_BEQ, S_JMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_IMM4 = 2'b11;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ctl_t;

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct field to ALU operation decode; valid is low for unsupported functs.
module mc_alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       valid_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        valid_o    = 1'b1;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: valid_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: Moore control decode per state plus a
// retired-instruction counter. All controls are forced low while in reset.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_wr,
    output logic             pc_wr_cond,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    ctl_t             ctl, ctl_o;
    logic [2:0]       fn_alu;
    logic             fn_ok;
    logic             retire;

    // zero qualifies the PC write in the datapath, not here
    logic unused_zero;
    assign unused_zero = zero;

    mc_alu_dec u_alu_dec (
        .funct_i    (funct),
        .alu_ctrl_o (fn_alu),
        .valid_o    (fn_ok)
    );

    always_comb begin
        ctl     = '0;
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                ctl.mem_rd    = 1'b1;
                ctl.ir_wr     = 1'b1;
                ctl.alu_src_b = ALUB_FOUR;
                ctl.alu_ctrl  = ALU_ADD;
                ctl.pc_src    = PCSRC_ALU;
                ctl.pc_wr     = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                ctl.alu_src_b = ALUB_IMM4;
                ctl.alu_ctrl  = ALU_ADD;
                ctl.illegal   = !op_known(op);
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_RTYPE:     state_d = S_R_EXE;
                    OP_ADDI:      state_d = S_I_EXE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_IMM;
                ctl.alu_ctrl  = ALU_ADD;
                state_d       = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.mem_rd = 1'b1;
                ctl.iord   = 1'b1;
                state_d    = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.reg_wr     = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_wr = 1'b1;
                ctl.iord   = 1'b1;
            end
            S_R_EXE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_REG;
                ctl.alu_ctrl  = fn_alu;
                ctl.illegal   = !fn_ok;
                state_d       = fn_ok ? S_R_WB : S_FETCH;
            end
            S_R_WB: begin
                ctl.reg_wr  = 1'b1;
                ctl.reg_dst = 1'b1;
            end
            S_I_EXE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_IMM;
                ctl.alu_ctrl  = ALU_ADD;
                state_d       = S_I_WB;
            end
            S_I_WB: ctl.reg_wr = 1'b1;
            S_BEQ: begin
                ctl.alu_src_a  = 1'b1;
                ctl.alu_src_b  = ALUB_REG;
                ctl.alu_ctrl   = ALU_SUB;
                ctl.pc_wr_cond = 1'b1;
                ctl.pc_src     = PCSRC_ALUOUT;
            end
            S_JMP: begin
                ctl.pc_wr  = 1'b1;
                ctl.pc_src = PCSRC_JUMP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign retire = (state_q == S_MEM_WB) || (state_q == S_MEM_WR) ||
                    (state_q == S_R_WB)   || (state_q == S_I_WB)   ||
                    (state_q == S_BEQ)    || (state_q == S_JMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    // FETCH would otherwise drive its strobes while reset is held
    assign ctl_o = rst_n ? ctl : '0;

    assign pc_wr      = ctl_o.pc_wr;
    assign pc_wr_cond = ctl_o.pc_wr_cond;
    assign pc_src     = ctl_o.pc_src;
    assign iord       = ctl_o.iord;
    assign mem_rd     = ctl_o.mem_rd;
    assign mem_wr     = ctl_o.mem_wr;
    assign ir_wr      = ctl_o.ir_wr;
    assign reg_wr     = ctl_o.reg_wr;
    assign reg_dst    = ctl_o.reg_dst;
    assign mem_to_reg = ctl_o.mem_to_reg;
    assign alu_src_a  = ctl_o.alu_src_a;
    assign alu_src_b  = ctl_o.alu_src_b;
    assign alu_ctrl   = ctl_o.alu_ctrl;
    assign illegal    = ctl_o.illegal;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and random instruction streams against a per-instruction
// table model of the expected control outputs per cycle and the retired count.
module tb_mc_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ov_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    op = '0, funct = '0;
    logic          zero = 1'b0;
    logic          pc_wr, pc_wr_cond, iord, mem_rd, mem_wr, ir_wr, reg_wr;
    logic          reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0]    pc_src, alu_src_b;
    logic [2:0]    alu_ctrl;
    logic [CW-1:0] retired;

    int n_cmp = 0, n_err = 0;
    int ret_m = 0;
    ov_t exp_q[$];
    bit  exp_ill;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .pc_src(pc_src), .iord(iord),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_wr(ir_wr), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic ov_t cur();
        return {pc_wr, pc_wr_cond, pc_src, iord, mem_rd, mem_wr, ir_wr, reg_wr,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected control vector per cycle, straight from the per-state output table.
    task automatic build(input logic [5:0] o, input logic [5:0] f);
        ov_t e;
        bit  fv;
        logic [2:0] ac;
        exp_q.delete();
        exp_ill = 1'b0;
        e = '0; e.pc_wr = 1; e.mem_rd = 1; e.ir_wr = 1; e.alu_src_b = 2'b01;
        exp_q.push_back(e);
        e = '0; e.alu_src_b = 2'b11;
        if (!(o inside {6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02})) begin
            e.illegal = 1; exp_ill = 1'b1;
        end
        exp_q.push_back(e);
        case (o)
            6'h23, 6'h2B: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; exp_q.push_back(e);
                if (o == 6'h23) begin
                    e = '0; e.mem_rd = 1; e.iord = 1; exp_q.push_back(e);
                    e = '0; e.reg_wr = 1; e.mem_to_reg = 1; exp_q.push_back(e);
                end else begin
                    e = '0; e.mem_wr = 1; e.iord = 1; exp_q.push_back(e);
                end
            end
            6'h00: begin
                fv = 1'b1;
                case (f)
                    6'h20: ac = 3'b000;
                    6'h22: ac = 3'b001;
                    6'h24: ac = 3'b010;
                    6'h25: ac = 3'b011;
                    6'h2A: ac = 3'b100;
                    default: begin ac = 3'b000; fv = 1'b0; end
                endcase
                e = '0; e.alu_src_a = 1; e.alu_ctrl = ac; e.illegal = !fv;
                exp_q.push_back(e);
                if (fv) begin
                    e = '0; e.reg_wr = 1; e.reg_dst = 1; exp_q.push_back(e);
                end else exp_ill = 1'b1;
            end
            6'h08: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; exp_q.push_back(e);
                e = '0; e.reg_wr = 1; exp_q.push_back(e);
            end
            6'h04: begin
                e = '0; e.alu_src_a = 1; e.alu_ctrl = 3'b001; e.pc_wr_cond = 1;
                e.pc_src = 2'b01; exp_q.push_back(e);
            end
            6'h02: begin
                e = '0; e.pc_wr = 1; e.pc_src = 2'b10; exp_q.push_back(e);
            end
            default: ;
        endcase
    endtask

    // Called just after a rising edge with the DUT expected in FETCH.
    task automatic run(input logic [5:0] o, input logic [5:0] f);
        build(o, f);
        op = o; funct = f;
        for (int i = 0; i < exp_q.size(); i++) begin
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("ctl op%0h fn%0h cyc%0d", o, f, i + 1), 32'(cur()), 32'(exp_q[i]));
            chk($sformatf("ret op%0h cyc%0d", o, i + 1), 32'(retired), 32'(ret_m));
            @(posedge clk); #1;
        end
        if (!exp_ill) ret_m = (ret_m + 1) % (1 << CW);
    endtask

    initial begin
        logic [5:0] o, f;
        logic [5:0] legal_ops[6];
        logic [5:0] fns[5];
        legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        // held in reset: everything low, FETCH decode included
        repeat (2) @(negedge clk);
        chk("rst ctl", 32'(cur()), 32'h0);
        chk("rst ret", 32'(retired), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        run(6'h23, 6'h00);
        chk("lw retired", 32'(retired), 32'd1);
        run(6'h00, 6'h2A);
        zero = 1'b1; run(6'h04, 6'h00);
        zero = 1'b0; run(6'h04, 6'h00);
        chk("beq retired", 32'(retired), 32'd4);
        run(6'h3F, 6'h00);
        run(6'h00, 6'h01);
        chk("illegal retired", 32'(retired), 32'd4);
        run(6'h2B, 6'h00);
        run(6'h08, 6'h00);

        // reset dropped in MEM_RD of a lw: outputs low at once, no write-back
        op = 6'h23; funct = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst ctl", 32'(cur()), 32'h0);
        chk("midrst ret", 32'(retired), 32'h0);
        ret_m = 0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst hold", 32'(cur()), 32'h0);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        // counter wrap through 16 jumps
        for (int i = 0; i < 16; i++) run(6'h02, 6'h00);
        chk("wrap", 32'(retired), 32'd0);

        for (int i = 0; i < 80; i++) begin
            o = legal_ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) begin
                do o = 6'($urandom); while (o inside {6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02});
            end
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run(o, f);
        end
        @(negedge clk);
        chk("final fetch ir_wr", 32'(ir_wr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 op  in  6  instruction opcode field from the instruction register.
REQ-005 funct  in  6  R-type function field.
REQ-006 zero  in  1  ALU zero flag from the current cycle.
REQ-007 pc_wr  out  1  unconditional PC load.
REQ-008 pc_wr_cond  out  1  PC load qualified by zero.
REQ-009 pc_src  out  2  00 ALU result, 01 ALU-out register, 10 jump target.
REQ-010 iord  out  1  memory address select; 0 PC, 1 ALU-out.
REQ-011 mem_rd / mem_wr  out  1 each  memory read / write strobes.
REQ-012 ir_wr  out  1  instruction-register load.
REQ-013 reg_wr  out  1  register-file write enable (drives r3_wr).
REQ-014 reg_dst  out  1  write address select; 0 rt, 1 rd (drives r3_addr mux).
REQ-015 mem_to_reg  out  1  write data select; 0 ALU-out, 1 memory data register.
REQ-016 alu_src_a  out  1  0 PC, 1 register A.
REQ-017 alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
REQ-018 alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-019 illegal  out  1  one-cycle pulse on an unsupported op/funct.
REQ-020 retired  out  CNT_W  count of completed instructions.

Function
REQ-021 States SHALL be FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EXE, R_WB, I_EXE, I_WB, BEQ, JMP.
REQ-022 FETCH: mem_rd=1, ir_wr=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00, pc_wr=1 -> DECODE.
REQ-023 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add; next state by op: 0x23/0x2B -> MEM_ADR, 0x00 -> R_EXE, 0x08 -> I_EXE, 0x04 -> BEQ, 0x02 -> JMP, other -> FETCH with illegal=1.
REQ-024 MEM_ADR: alu_src_a=1, alu_src_b=10, add; lw -> MEM_RD, sw -> MEM_WR.
REQ-025 MEM_RD: mem_rd=1, iord=1 -> MEM_WB; MEM_WB: reg_wr=1, reg_dst=0, mem_to_reg=1 -> FETCH.
REQ-026 MEM_WR: mem_wr=1, iord=1 -> FETCH.
REQ-027 R_EXE: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt); unsupported funct -> FETCH with illegal=1, no write; else -> R_WB.
REQ-028 R_WB: reg_wr=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-029 I_EXE: alu_src_a=1, alu_src_b=10, add -> I_WB; I_WB: reg_wr=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-030 BEQ: alu_src_a=1, alu_src_b=00, sub, pc_wr_cond=1, pc_src=01 -> FETCH.
REQ-031 JMP: pc_wr=1, pc_src=10 -> FETCH.
REQ-032 Outputs SHALL be Moore (decoded from state, plus funct in R_EXE); any output not listed for a state SHALL be 0.
REQ-033 Latency in cycles, FETCH inclusive: lw 5; sw, R-type, addi 4; beq, j 3; illegal 2.
REQ-034 retired SHALL increment by 1 on the clock edge leaving MEM_WB, MEM_WR, R_WB, I_WB, BEQ, JMP; it SHALL wrap from all-ones to 0; illegal instructions SHALL not count.
REQ-035 reg_wr SHALL be asserted at most one cycle per instruction.

Reset
REQ-036 rst_n low SHALL asynchronously force state FETCH and retired=0.
REQ-037 While rst_n is low, every control output SHALL be 0, FETCH decoding included.
REQ-038 Reset asserted mid-instruction SHALL abort it with no reg_wr/mem_wr afterwards; the first cycle after release SHALL be FETCH.

Structure
REQ-039 State encoding, opcode/funct constants and alu_ctrl codes SHALL live in shared package mips_pkg.
REQ-040 funct-to-alu_ctrl decode SHALL be sub-module mc_alu_dec (combinational, with a valid output).

Verification
REQ-041 Reset release, op=0x23 held -> states FETCH,DECODE,MEM_ADR,MEM_RD,MEM_WB; reg_wr=1, mem_to_reg=1 only in cycle 5; retired=1.
REQ-042 op=0x00, funct=0x2A -> alu_ctrl=100 in R_EXE, reg_wr=1 with reg_dst=1 in cycle 4.
REQ-043 op=0x04 with zero=1, then zero=0 -> pc_wr_cond=1, pc_src=01 in cycle 3 both times; retired +2.
REQ-044 op=0x3F -> illegal pulse in DECODE, back to FETCH in cycle 3, retired unchanged; op=0x00, funct=0x01 -> illegal in R_EXE, no reg_wr.
REQ-045 rst_n dropped during MEM_RD -> all outputs 0 immediately, no MEM_WB write; FETCH after release.
REQ-046 CNT_W=4, 16 j instructions -> retired wraps 15 -> 0.
